// File: rtl/vga_frame_out.sv
// Pixel FIFO feeding a free-running SVGA timing generator; the image occupies the
// top-left IMG_W x IMG_H corner of the active area, with all outputs registered together.
module vga_frame_out #(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int H_ACT      = 800,
  parameter int H_FP       = 40,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int V_ACT      = 600,
  parameter int V_FP       = 1,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid_in,
  output logic       pixel_ready_out,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       HS_out,
  output logic       VS_out,
  output logic       frame_done,
  output logic       underrun
);

  localparam int H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int H_IMG0 = H_SYNC + H_BP;
  localparam int H_IMG1 = H_IMG0 + IMG_W - 1;
  localparam int V_IMG0 = V_SYNC + V_BP;
  localparam int V_IMG1 = V_IMG0 + IMG_H - 1;

  typedef enum logic {ST_WAIT, ST_SHOW} state_t;

  // Handshake: a pixel transfers on a rising edge where pixel_valid_in && pixel_ready_out.
  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rdy_en_q;
  logic [7:0]      pix_q, pix_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            fd_q, fd_d;
  logic            und_q, und_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic h_last, v_last, in_win, show_px, push, pop;

  assign pixel_ready_out = rdy_en_q && (count_q != CW'(FIFO_DEPTH));
  assign R_out      = pix_q;
  assign G_out      = pix_q;
  assign B_out      = pix_q;
  assign HS_out     = hs_q;
  assign VS_out     = vs_q;
  assign frame_done = fd_q;
  assign underrun   = und_q;

  always_comb begin
    h_last  = (h_cnt_q == HW'(H_TOT - 1));
    v_last  = (v_cnt_q == VW'(V_TOT - 1));
    in_win  = (h_cnt_q >= HW'(H_IMG0)) && (h_cnt_q <= HW'(H_IMG1)) &&
              (v_cnt_q >= VW'(V_IMG0)) && (v_cnt_q <= VW'(V_IMG1));
    show_px = (state_q == ST_SHOW) && in_win;
    push    = pixel_valid_in && pixel_ready_out;
    // An empty FIFO in the window is an underrun: no pop, black pixel.
    pop     = show_px && (count_q != '0);

    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    pix_d = pop ? mem[rd_ptr_q] : 8'h00;
    hs_d  = !(h_cnt_q < HW'(H_SYNC));
    vs_d  = !(v_cnt_q < VW'(V_SYNC));
    fd_d  = (state_q == ST_SHOW) && (h_cnt_q == HW'(H_IMG1)) && (v_cnt_q == VW'(V_IMG1));
    und_d = und_q || (show_px && (count_q == '0));

    state_d = state_q;
    case (state_q)
      ST_WAIT: if (h_last && v_last && (count_q >= CW'(IMG_W))) state_d = ST_SHOW;
      ST_SHOW: if (fd_d) state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
      pix_q    <= 8'h00;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fd_q     <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_en_q <= 1'b1;
      pix_q    <= pix_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fd_q     <= fd_d;
      und_q    <= und_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pixel_in;
  end

endmodule

// File: tb/tb_vga_frame_out.sv
// Directed bench for vga_frame_out using a shrunken raster (21 x 11, 8 x 4 image)
// so whole frames fit in a short run.
module tb_vga_frame_out;

  localparam int IMG_W = 8, IMG_H = 4;
  localparam int H_SYNC = 4, H_BP = 3, H_ACT = 12, H_FP = 2;
  localparam int V_SYNC = 2, V_BP = 2, V_ACT = 6, V_FP = 1;
  localparam int DEPTH = 16;
  localparam int HT = 21, VT = 11, FT = HT * VT;
  localparam int HI0 = 7, VI0 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic       pixel_valid_in = 1'b0;
  logic       pixel_ready_out;
  logic [7:0] R_out, G_out, B_out;
  logic       HS_out, VS_out, frame_done, underrun;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [7:0] exp_q[$];

  vga_frame_out #(
    .IMG_W(IMG_W), .IMG_H(IMG_H),
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
    .pixel_ready_out(pixel_ready_out), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HS_out(HS_out), .VS_out(VS_out), .frame_done(frame_done), .underrun(underrun)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Rising edges since reset release; a sample taken at cyc shows counter state t = cyc-1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic do_reset();
    rst = 1'b1;
    pixel_valid_in = 1'b0;
    pixel_in = 8'h00;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives the next pixel of a base+index sequence, limited to n pixels.
  task automatic drive_px(input int n, input logic [7:0] base, inout int idx);
    if (idx < n) begin
      pixel_valid_in = 1'b1;
      pixel_in = base + idx[7:0];
      if (pixel_ready_out) idx++;
    end else begin
      pixel_valid_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({R_out, G_out, B_out} !== 24'h0 || HS_out !== 1'b1 || VS_out !== 1'b1 ||
        frame_done !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rgb=%h hs=%b vs=%b fd=%b und=%b, want 0 1 1 0 0",
               {R_out, G_out, B_out}, HS_out, VS_out, frame_done, underrun);
    end
    checks++;
    if (pixel_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", pixel_ready_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pixel_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b want 1", pixel_ready_out);
    end
    checks++;
    if (HS_out !== 1'b0 || VS_out !== 1'b0) begin
      errors++;
      $display("FAIL first_sync: hs=%b vs=%b want 0 0", HS_out, VS_out);
    end
  endtask

  task automatic test_sync();
    int hs_low = 0, vs_low = 0, hs_err = 0, vs_err = 0, rgb_nz = 0, und_n = 0, fd_n = 0, t;
    do_reset();
    for (int k = 0; k < 2 * FT; k++) begin
      @(negedge clk);
      t = cyc - 1;
      if (!HS_out) hs_low++;
      if (!VS_out) vs_low++;
      if (HS_out !== ((t % HT) >= H_SYNC)) hs_err++;
      if (VS_out !== (((t / HT) % VT) >= V_SYNC)) vs_err++;
      if ({R_out, G_out, B_out} !== 24'h0) rgb_nz++;
      if (underrun !== 1'b0) und_n++;
      if (frame_done !== 1'b0) fd_n++;
    end
    checks++;
    if (hs_low != 2 * VT * H_SYNC) begin
      errors++; $display("FAIL hs_low_count: got %0d want %0d", hs_low, 2 * VT * H_SYNC);
    end
    checks++;
    if (vs_low != 2 * V_SYNC * HT) begin
      errors++; $display("FAIL vs_low_count: got %0d want %0d", vs_low, 2 * V_SYNC * HT);
    end
    checks++;
    if (hs_err != 0 || vs_err != 0) begin
      errors++; $display("FAIL sync_position: hs_err=%0d vs_err=%0d want 0 0", hs_err, vs_err);
    end
    checks++;
    if (rgb_nz != 0 || und_n != 0 || fd_n != 0) begin
      errors++;
      $display("FAIL idle_outputs: rgb_nz=%0d und=%0d fd=%0d want 0 0 0", rgb_nz, und_n, fd_n);
    end
  endtask

  task automatic test_preload();
    int idx = 0, fd_n = 0;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < 2 * FT; k++) begin
      @(negedge clk);
      drive_px(IMG_W, 8'h00, idx);
      if (frame_done) fd_n++;
      if (cyc >= 322 && cyc <= 331) begin
        want = (cyc >= 323 && cyc <= 330) ? 8'(cyc - 323) : 8'h00;
        checks++;
        if ({R_out, G_out, B_out} !== {want, want, want}) begin
          errors++;
          $display("FAIL preload_px cyc=%0d: rgb=%h want %h%h%h", cyc,
                   {R_out, G_out, B_out}, want, want, want);
        end
      end
      if (cyc == 343 || cyc == 344) begin
        checks++;
        if (underrun !== (cyc == 344)) begin
          errors++;
          $display("FAIL preload_underrun cyc=%0d: got %b want %b", cyc, underrun, cyc == 344);
        end
      end
      if (cyc == 392 || cyc == 393) begin
        checks++;
        if (frame_done !== (cyc == 393)) begin
          errors++;
          $display("FAIL preload_frame_done cyc=%0d: got %b want %b", cyc, frame_done, cyc == 393);
        end
      end
    end
    checks++;
    if (fd_n != 1) begin
      errors++; $display("FAIL preload_fd_count: got %0d want 1", fd_n);
    end
  endtask

  task automatic test_stream();
    int idx = 0, t, f, h, v, fd_n = 0, fd_err = 0, nz = 0, ready_low = 0;
    logic [7:0] want;
    bit win;
    do_reset();
    for (int k = 0; k < 4 * FT; k++) begin
      @(negedge clk);
      t = cyc - 1; f = t / FT; h = t % HT; v = (t / HT) % VT;
      win = (f >= 1) && (f <= 3) && (h >= HI0) && (h < HI0 + IMG_W) && (v >= VI0) && (v < VI0 + IMG_H);
      if (win) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_queue_empty cyc=%0d: rgb=%h", cyc, R_out);
        end else begin
          want = exp_q.pop_front();
          if ({R_out, G_out, B_out} !== {want, want, want}) begin
            errors++;
            $display("FAIL stream_px cyc=%0d: rgb=%h want %h", cyc, {R_out, G_out, B_out}, want);
          end
        end
      end else if ({R_out, G_out, B_out} !== 24'h0) begin
        nz++;
      end
      if (frame_done) fd_n++;
      if (frame_done !== ((f >= 1) && (f <= 3) && h == HI0 + IMG_W - 1 && v == VI0 + IMG_H - 1)) fd_err++;
      if (cyc == 16 || cyc == 17) begin
        checks++;
        if (pixel_ready_out !== (cyc == 16)) begin
          errors++;
          $display("FAIL stream_ready_full cyc=%0d: got %b want %b", cyc, pixel_ready_out, cyc == 16);
        end
      end
      if (pixel_valid_in && !pixel_ready_out) ready_low++;
      // Scoreboard entry for each pixel accepted at the coming edge.
      if (idx < 128) begin
        pixel_valid_in = 1'b1;
        pixel_in = 8'((idx * 3 + 1) & 255);
        if (pixel_ready_out) begin
          exp_q.push_back(pixel_in);
          idx++;
        end
      end else begin
        pixel_valid_in = 1'b0;
      end
    end
    pixel_valid_in = 1'b0;
    checks++;
    if (fd_n != 3 || fd_err != 0) begin
      errors++; $display("FAIL stream_frame_done: pulses=%0d misplaced=%0d want 3 0", fd_n, fd_err);
    end
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL stream_blanking: nonzero=%0d want 0", nz);
    end
    checks++;
    if (underrun !== 1'b0 || ready_low == 0) begin
      errors++; $display("FAIL stream_flow: und=%b ready_low=%0d want 0 >0", underrun, ready_low);
    end
  endtask

  task automatic test_underrun();
    int idx = 0, hs_err = 0, drop = 0, t;
    logic [7:0] want;
    do_reset();
    for (int k = 0; k < 2 * FT; k++) begin
      @(negedge clk);
      drive_px(11, 8'h40, idx);
      t = cyc - 1;
      if (HS_out !== ((t % HT) >= H_SYNC)) hs_err++;
      if (cyc >= 347 && underrun !== 1'b1) drop++;
      if (cyc == 323 || (cyc >= 344 && cyc <= 348)) begin
        case (cyc)
          323:     want = 8'h40;
          344:     want = 8'h48;
          345:     want = 8'h49;
          346:     want = 8'h4A;
          default: want = 8'h00;
        endcase
        checks++;
        if ({R_out, G_out, B_out} !== {want, want, want}) begin
          errors++;
          $display("FAIL underrun_px cyc=%0d: rgb=%h want %h", cyc, {R_out, G_out, B_out}, want);
        end
      end
      if (cyc == 346 || cyc == 347) begin
        checks++;
        if (underrun !== (cyc == 347)) begin
          errors++;
          $display("FAIL underrun_flag cyc=%0d: got %b want %b", cyc, underrun, cyc == 347);
        end
      end
    end
    checks++;
    if (drop != 0) begin
      errors++; $display("FAIL underrun_sticky: cleared on %0d samples want 0", drop);
    end
    checks++;
    if (hs_err != 0) begin
      errors++; $display("FAIL underrun_sync: hs_err=%0d want 0", hs_err);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    logic [7:0] want;
    do_reset();
    while (cyc < 326) begin
      @(negedge clk);
      drive_px(DEPTH, 8'h10, idx);
    end
    pixel_valid_in = 1'b0;
    checks++;
    if (R_out !== 8'h13) begin
      errors++; $display("FAIL mid_before_reset: rgb=%h want 13", R_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({R_out, G_out, B_out} !== 24'h0 || HS_out !== 1'b1 || VS_out !== 1'b1 ||
        frame_done !== 1'b0 || underrun !== 1'b0 || pixel_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rgb=%h hs=%b vs=%b fd=%b und=%b rdy=%b want 0 1 1 0 0 0",
               {R_out, G_out, B_out}, HS_out, VS_out, frame_done, underrun, pixel_ready_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idx = 0;
    while (cyc < 331) begin
      @(negedge clk);
      drive_px(IMG_W, 8'hA0, idx);
      if (cyc == 4 || cyc == 5) begin
        checks++;
        if (HS_out !== (cyc == 5)) begin
          errors++; $display("FAIL mid_restart_hs cyc=%0d: got %b want %b", cyc, HS_out, cyc == 5);
        end
      end
      if (cyc >= 323 && cyc <= 330) begin
        want = 8'hA0 + 8'(cyc - 323);
        checks++;
        if (R_out !== want) begin
          errors++; $display("FAIL mid_fifo_cleared cyc=%0d: rgb=%h want %h", cyc, R_out, want);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sync();
    test_preload();
    test_stream();
    test_underrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
